// File: rtl/width_packer.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one registered
// OUT_W word, with selectable lane order and partial-word flush on input gaps.
module width_packer #(
  parameter int IN_W = 8,
  parameter int RATIO = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FLUSH_PARTIAL = 1'b1,
  parameter logic [IN_W-1:0] PAD = '0
) (
  input  logic                          clk_4f,
  input  logic                          reset_L,
  input  logic [IN_W-1:0]               data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [IN_W*RATIO-1:0]         data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          partial_out,
  output logic [$clog2(RATIO+1)-1:0]    lanes_out
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW = $clog2(RATIO + 1);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             part_q, part_d;
  logic [CW-1:0]    lanes_q, lanes_d;

  logic             slot_free;
  logic             last_lane;
  logic             accept;
  logic [OUT_W-1:0] pad_word;

  function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] w,
                                             input logic [CW-1:0] k,
                                             input logic [IN_W-1:0] b);
    logic [OUT_W-1:0] r;
    r = w;
    if (MSB_FIRST) r[OUT_W-1-int'(k)*IN_W -: IN_W] = b;
    else           r[int'(k)*IN_W +: IN_W] = b;
    return r;
  endfunction

  assign pad_word  = {RATIO{PAD}};
  assign slot_free = !valid_q || ready_in;
  assign last_lane = (cnt_q == CW'(RATIO - 1));
  // Only the completing lane needs the output slot; earlier lanes go to the accumulator.
  assign ready_out = (state_q != FLUSH) && (!last_lane || slot_free);
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    part_d  = part_q;
    lanes_d = lanes_q;
    if (valid_q && ready_in) valid_d = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (last_lane) begin
            data_d  = place(acc_q, cnt_q, data_in);
            valid_d = 1'b1;
            part_d  = 1'b0;
            lanes_d = CW'(RATIO);
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            // First lane pre-fills the rest with PAD so a flush can emit acc_q as-is.
            acc_d   = place((cnt_q == '0) ? pad_word : acc_q, cnt_q, data_in);
            cnt_d   = cnt_q + CW'(1);
            state_d = FILL;
          end
        end else if (state_q == FILL && !valid_in) begin
          if (!FLUSH_PARTIAL) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (slot_free) begin
            data_d  = acc_q;
            valid_d = 1'b1;
            part_d  = 1'b1;
            lanes_d = cnt_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          data_d  = acc_q;
          valid_d = 1'b1;
          part_d  = 1'b1;
          lanes_d = cnt_q;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      part_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      part_q  <= part_d;
      lanes_q <= lanes_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign partial_out = part_q;
  assign lanes_out   = lanes_q;

endmodule
